sha256_padder: RTL and testbench

- Upstream feeder for the SHA256 core. Accepts a message as a byte stream and emits SHA-256 padded 512-bit blocks, each ready to drive the core's 512-bit input directly.
- Padding per FIPS 180-4: 0x80 marker byte, zero fill, 64-bit big-endian message bit length in the final block.
- Emits one extra block when the length field does not fit in the block holding the last data byte.
- Block output uses a valid/ready handshake so the hash stage can back-pressure.

---
 rtl/sha256_padder.sv | 166 ++++++++++++++++
 tb/tb_sha256_padder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length, and presents each
// block to the hash core through a valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   FILL  | accepting message bytes into the block buffer
//   PAD   | one cycle: place 0x80 at ptr, zero the tail, add length if it fits
//   LEN   | one cycle: build a length-only block (zeros + bit length)
//   EMIT  | block presented on blk_data; waits for blk_ready
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  // ptr counts 0..64 so it needs one bit more than a byte index
  logic [6:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             pend_pad, pend_pad_nxt;
  logic             pend_len, pend_len_nxt;
  logic [511:0]     blk_buf, blk_buf_nxt;
  logic             last_q, last_nxt;
  logic             accept;
  logic             has_byte;
  logic [63:0]      bit_len;

  assign in_ready  = (state == FILL) && !reset;
  assign blk_valid = (state == EMIT);
  assign blk_data  = blk_buf;
  assign blk_last  = last_q;

  assign accept = in_valid && in_ready;
  // an empty beat never carries a byte, whether or not it is the last one
  assign has_byte = !in_empty;
  // byte count shifted to bits; wraps naturally with the counter width
  assign bit_len = 64'({count, 3'b000});

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: buffer, pointer, byte count and pending follow-on flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      count    <= '0;
      pend_pad <= 1'b0;
      pend_len <= 1'b0;
      blk_buf  <= '0;
      last_q   <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      count    <= count_nxt;
      pend_pad <= pend_pad_nxt;
      pend_len <= pend_len_nxt;
      blk_buf  <= blk_buf_nxt;
      last_q   <= last_nxt;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    count_nxt    = count;
    pend_pad_nxt = pend_pad;
    pend_len_nxt = pend_len;
    blk_buf_nxt  = blk_buf;
    last_nxt     = last_q;

    case (state)
      FILL: begin
        if (accept) begin
          if (has_byte) begin
            for (int i = 0; i < 64; i++) begin
              if (7'(i) == ptr) blk_buf_nxt[511-8*i -: 8] = in_data;
            end
            ptr_nxt   = ptr + 7'd1;
            count_nxt = count + CNT_W'(1);
          end
          if (has_byte && (ptr == 7'd63)) begin
            // block full; a final byte here still owes a padding block
            state_nxt    = EMIT;
            last_nxt     = 1'b0;
            pend_pad_nxt = in_last;
          end else if (in_last) begin
            state_nxt = PAD;
          end
        end
      end

      PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (7'(i) == ptr) begin
            blk_buf_nxt[511-8*i -: 8] = 8'h80;
          end else if (7'(i) > ptr) begin
            blk_buf_nxt[511-8*i -: 8] = 8'h00;
          end
        end
        if (ptr <= 7'd55) begin
          blk_buf_nxt[63:0] = bit_len;
          last_nxt          = 1'b1;
        end else begin
          // marker landed in the last 8 bytes: length goes in an extra block
          last_nxt     = 1'b0;
          pend_len_nxt = 1'b1;
        end
        state_nxt = EMIT;
      end

      LEN: begin
        blk_buf_nxt = {448'd0, bit_len};
        last_nxt    = 1'b1;
        state_nxt   = EMIT;
      end

      EMIT: begin
        if (blk_ready) begin
          if (pend_pad) begin
            pend_pad_nxt = 1'b0;
            ptr_nxt      = '0;
            state_nxt    = PAD;
          end else if (pend_len) begin
            pend_len_nxt = 1'b0;
            state_nxt    = LEN;
          end else begin
            ptr_nxt     = '0;
            blk_buf_nxt = '0;
            state_nxt   = FILL;
            if (last_q) count_nxt = '0;
          end
        end
      end

      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: table-driven message vectors, randomized messages
// checked against a byte-queue padding model, and hand-written latency,
// back-pressure and reset sequences.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_ready;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_blk[$];
  logic         exp_last[$];
  int           seen_blocks;
  logic [63:0]  seen_len;
  logic [511:0] seen_blk;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};

  typedef struct {
    int          len;
    int          kind;        // 0: all 0xAA, 1: incrementing, 2: random
    bit          empty_term;  // terminate with a separate empty last beat
    int          exp_blocks;
    logic [63:0] exp_len;
  } vec_t;

  vec_t vecs[10];

  function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  function automatic void fail_timeout(string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Padding model: message + 0x80 + zeros up to 56 mod 64 + 64-bit bit length
  function automatic void build_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    logic [511:0] b;
    int nb;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    exp_blk.delete();
    exp_last.delete();
    for (int i = 0; i < nb; i++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*i+j];
      exp_blk.push_back(b);
      exp_last.push_back(i == nb - 1);
    end
  endfunction

  function automatic void fill_msg(int len, int kind);
    msg.delete();
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       msg.push_back(8'hAA);
        1:       msg.push_back(8'(i));
        default: msg.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endfunction

  // Presents one beat from a negedge and returns just after the accepting edge
  task automatic drive_beat(input logic [7:0] d, input logic l, input logic e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_empty = e;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_timeout("in_ready");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_empty = 1'b0;
    end
  endtask

  task automatic send_msg(input bit empty_term);
    for (int i = 0; i < msg.size(); i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      drive_beat(msg[i], (!empty_term && i == msg.size() - 1), 1'b0);
    end
    if (empty_term) drive_beat(8'($urandom_range(0, 255)), 1'b1, 1'b1);
  endtask

  task automatic collect(input int ready_pct);
    seen_blocks = 0;
    for (int b = 0; b < exp_blk.size(); b++) begin
      int t = 0;
      bit done = 0;
      while (!done && t < 3000) begin
        @(negedge clk);
        blk_ready = ($urandom_range(0, 99) < ready_pct);
        if (blk_valid && blk_ready) begin
          check($sformatf("blk_data[%0d]", b), blk_data, exp_blk[b]);
          check($sformatf("blk_last[%0d]", b), 512'(blk_last), 512'(exp_last[b]));
          seen_blocks++;
          seen_len = blk_data[63:0];
          seen_blk = blk_data;
          done = 1;
        end
        t++;
      end
      if (!done) begin
        fail_timeout("blk_valid");
        blk_ready = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      blk_ready = 1'b0;
    end
  endtask

  task automatic run_msg(input bit empty_term, input int ready_pct);
    int extra = 0;
    build_expected();
    fork
      send_msg(empty_term);
      collect(ready_pct);
    join
    repeat (4) begin
      @(negedge clk);
      if (blk_valid) extra++;
    end
    check("no_extra_blk", 512'(extra), 512'd0);
  endtask

  initial begin
    vecs[0] = '{len: 0,   kind: 0, empty_term: 1, exp_blocks: 1, exp_len: 64'h0};
    vecs[1] = '{len: 55,  kind: 0, empty_term: 0, exp_blocks: 1, exp_len: 64'h1B8};
    vecs[2] = '{len: 56,  kind: 0, empty_term: 0, exp_blocks: 2, exp_len: 64'h1C0};
    vecs[3] = '{len: 128, kind: 1, empty_term: 0, exp_blocks: 3, exp_len: 64'h400};
    vecs[4] = '{len: 64,  kind: 1, empty_term: 1, exp_blocks: 2, exp_len: 64'h200};
    vecs[5] = '{len: 10,  kind: 2, empty_term: 1, exp_blocks: 1, exp_len: 64'h50};
    vecs[6] = '{len: 119, kind: 2, empty_term: 0, exp_blocks: 2, exp_len: 64'h3B8};
    vecs[7] = '{len: 120, kind: 2, empty_term: 0, exp_blocks: 3, exp_len: 64'h3C0};
    vecs[8] = '{len: 63,  kind: 2, empty_term: 0, exp_blocks: 2, exp_len: 64'h1F8};
    vecs[9] = '{len: 1,   kind: 2, empty_term: 0, exp_blocks: 1, exp_len: 64'h8};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_empty  = 1'b0;
    blk_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'd0);
    check("rst_blk_valid", 512'(blk_valid), 512'd0);
    check("rst_blk_last", 512'(blk_last), 512'd0);
    check("rst_blk_data", blk_data, 512'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 512'(in_ready), 512'd1);

    // "abc": latency, back-pressure hold, then handshake
    drive_beat(8'h61, 1'b0, 1'b0);
    drive_beat(8'h62, 1'b0, 1'b0);
    drive_beat(8'h63, 1'b1, 1'b0);
    check("abc_lat_n1", 512'(blk_valid), 512'd0);
    @(posedge clk);
    #1;
    check("abc_lat_n2", 512'(blk_valid), 512'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_data", blk_data, ABC_BLK);
      check("hold_last", 512'(blk_last), 512'd1);
      check("hold_in_ready", 512'(in_ready), 512'd0);
    end
    @(negedge clk);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check("abc_drop_valid", 512'(blk_valid), 512'd0);
    check("abc_in_ready", 512'(in_ready), 512'd1);

    // full non-final block: valid one cycle after byte 63, reset inside EMIT
    for (int i = 0; i < 64; i++) drive_beat(8'(i), 1'b0, 1'b0);
    check("full_lat", 512'(blk_valid), 512'd1);
    check("full_last", 512'(blk_last), 512'd0);
    reset = 1'b1;
    #1;
    check("emit_rst_valid", 512'(blk_valid), 512'd0);
    check("emit_rst_data", blk_data, 512'd0);
    @(negedge clk);
    reset = 1'b0;

    // reset after 10 bytes discards them; "abc" follows cleanly
    for (int i = 0; i < 10; i++) drive_beat(8'hC0 + 8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 512'(in_ready), 512'd0);
    check("mid_rst_valid", 512'(blk_valid), 512'd0);
    @(negedge clk);
    reset = 1'b0;
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    run_msg(1'b0, 100);
    check("abc_after_rst_len", 512'(seen_len), 512'h18);
    check("abc_after_rst_blk", seen_blk, ABC_BLK);

    // table-driven vectors
    for (int v = 0; v < 10; v++) begin
      fill_msg(vecs[v].len, vecs[v].kind);
      run_msg(vecs[v].empty_term, 60);
      check($sformatf("vec%0d_blocks", v), 512'(seen_blocks), 512'(vecs[v].exp_blocks));
      check($sformatf("vec%0d_len", v), 512'(seen_len), 512'(vecs[v].exp_len));
    end

    // randomized messages against the padding model
    for (int r = 0; r < 20; r++) begin
      int  len;
      bit  et;
      len = $urandom_range(0, 200);
      et  = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      fill_msg(len, 2);
      run_msg(et, $urandom_range(30, 100));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
